// File: rtl/reg_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_share_pkg
// Shared definitions for the register-sharing arbiter:
//   arb_state_e        - arbiter FSM state (IDLE: rotate-priority search,
//                        LOCKED: grant held by one owner for a burst)
//   REG_SHARE_DATA_W   - default datapath width
//   REG_SHARE_MAX_REQ  - largest supported requester count
// -----------------------------------------------------------------------------
package reg_share_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int REG_SHARE_DATA_W  = 16;
    localparam int REG_SHARE_MAX_REQ = 16;

endpackage

// File: rtl/reg_share_arb_if.sv
// -----------------------------------------------------------------------------
// reg_share_arb_if
// Bundles the requester ports and the shared output slot of reg_share_arb.
//   req_valid [NUM_REQ]         - per-requester valid
//   req_data  [NUM_REQ*DATA_W]  - per-requester word, requester i at [i*DATA_W +: DATA_W]
//   req_ready [NUM_REQ]         - per-requester accept, one-hot or zero
//   out_valid                   - output slot holds a word
//   out_data  [DATA_W]          - registered word
//   out_src   [SRC_W]           - requester that supplied out_data
//   out_ready                   - consumer accepts the output word
// master: producers + consumer side; slave: the arbiter.
// -----------------------------------------------------------------------------
interface reg_share_arb_if
    import reg_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_SHARE_DATA_W,
    parameter int SRC_W   = $clog2(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        output out_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src,
        input  out_ready
    );

endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority selector: the first set bit of req found when
// searching ptr, ptr+1, ... modulo NUM_REQ.
//   req   [NUM_REQ] in  - request vector
//   ptr   [SRC_W]   in  - highest-priority index (must be < NUM_REQ)
//   grant [NUM_REQ] out - one-hot winner, zero when no request
//   idx   [SRC_W]   out - index of the winner (0 when none)
//   any             out - at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int                j;
        logic [SRC_W-1:0]  pos;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        pos   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Explicit wrap so non-power-of-two NUM_REQ never indexes past the end.
            j = int'(ptr) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            pos = SRC_W'(j);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/reg_share_arb.sv
// -----------------------------------------------------------------------------
// reg_share_arb
// Round-robin arbiter and burst sequencer feeding one shared registered
// output slot. A requester, once granted, keeps the grant for up to
// MAX_BURST consecutive transfers; the accepted word appears on out_data one
// cycle after acceptance, tagged with its source index.
//   clk  in - rising-edge clock
//   rst  in - synchronous, active-high reset
//   bus  reg_share_arb_if.slave - requester ports and output slot
// -----------------------------------------------------------------------------
module reg_share_arb
    import reg_share_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 2,
    parameter int DATA_W    = REG_SHARE_DATA_W,
    parameter int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    reg_share_arb_if.slave bus
);

    localparam int CNT_W = 4;

    arb_state_e         state_q, state_n;
    logic [SRC_W-1:0]   ptr_q, ptr_n;
    logic [SRC_W-1:0]   owner_q, owner_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic               slot_free;
    logic               xfer;
    logic [SRC_W-1:0]   xfer_idx;
    logic [DATA_W-1:0]  sel_data;

    logic               vld_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [SRC_W-1:0]   src_p1;

    // Increment modulo NUM_REQ by compare-and-clear.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] x);
        if (x == SRC_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return x + SRC_W'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant / ready / transfer decode
    always_comb begin
        slot_free = !vld_p1 || bus.out_ready;
        owner_oh  = '0;
        owner_oh[owner_q] = 1'b1;
        grant     = '0;
        if (state_q == IDLE) begin
            grant = pick_any ? pick_grant : '0;
        end else if (bus.req_valid[owner_q]) begin
            grant = owner_oh;
        end
        ready    = (rst || !slot_free) ? '0 : grant;
        xfer     = |(bus.req_valid & ready);
        xfer_idx = (state_q == IDLE) ? pick_idx : owner_q;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM next state; everything holds while the slot is occupied and not drained
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        owner_n = owner_q;
        cnt_n   = cnt_q;
        if (slot_free) begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        if (MAX_BURST == 1) begin
                            ptr_n = wrap_inc(xfer_idx);
                        end else begin
                            state_n = LOCKED;
                            owner_n = xfer_idx;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (!bus.req_valid[owner_q]) begin
                        // Owner went away: release with one bubble cycle.
                        state_n = IDLE;
                        ptr_n   = wrap_inc(owner_q);
                        cnt_n   = '0;
                    end else if (xfer) begin
                        if ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
                            state_n = IDLE;
                            ptr_n   = wrap_inc(owner_q);
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            owner_q <= owner_n;
            cnt_q   <= cnt_n;
        end
    end

    // Stage p1: shared output slot. A transfer refills it even while draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= sel_data;
            src_p1  <= xfer_idx;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_src   = src_p1;

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter and burst sequencer that shares one 16-bit registered datapath stage (capture on `clk`, one-cycle delay) among `NUM_REQ` requesters. Each requester offers a word through a valid/ready port. The block selects one requester, holds the grant for up to `MAX_BURST` consecutive transfers, and registers the selected word into a single output slot with a source tag. It sits between the stimulus/producer ports of a test-vector design and the shared register stage whose VCD trace is inspected downstream.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `MAX_BURST`, default 2: maximum consecutive transfers per grant, 1..15.
- `DATA_W`, default 16: data width.
- `SRC_W`, default `$clog2(NUM_REQ)`: width of the source tag.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ×DATA_W  per-requester word, packed, requester i at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `out_valid`  out  1  output slot holds a word.
- `out_data`  out  DATA_W  registered word.
- `out_src`  out  SRC_W  index of the requester that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the output word.

## Operation
- **Reset values:** `out_valid`=0, `out_data`=0, `out_src`=0, state=IDLE, `ptr`=0, `owner`=0, `cnt`=0.
- **Slot free:** `slot_free = !out_valid || out_ready`.
- **Ready:** `req_ready[i] = grant[i] && slot_free`.
- **Transfer:** a transfer on port i happens when `req_valid[i] && req_ready[i]`.
- **IDLE state:**
  - `grant` is the first requester with valid set, searching i = ptr, ptr+1, … mod NUM_REQ. It is zero if no requester is valid.
  - On a transfer from requester k:
    - If MAX_BURST=1: stay in IDLE and set `ptr` ← (k+1) mod NUM_REQ.
    - Otherwise: go to LOCKED with `owner` ← k and `cnt` ← 1.
- **LOCKED state:**
  - `grant` = one-hot(`owner`) when `req_valid[owner]` is high; zero otherwise.
  - Owner's valid low: go to IDLE and set `ptr` ← owner+1. This costs one bubble cycle with no grant.
  - Transfer with cnt+1 == MAX_BURST: go to IDLE, set `ptr` ← owner+1, set `cnt` ← 0.
  - Transfer otherwise: `cnt` ← cnt+1.
- **Stall:** when `slot_free`=0, nothing transfers and state, `ptr`, `owner` and `cnt` all hold. Requests from other requesters are not granted while LOCKED.
- **Output register:**
  - On a transfer: `out_data` ← `req_data[k]`, `out_src` ← k, `out_valid` ← 1.
  - Else if `out_ready`: `out_valid` ← 0. `out_data` and `out_src` hold their last value.
- **Width rule:** `ptr` and `owner` wrap modulo NUM_REQ. This is an explicit compare-and-clear, not natural overflow, when NUM_REQ is not a power of two.

## Timing
- Arbitration is combinational within the cycle. `req_ready` depends on `req_valid`, state and `out_ready` in the same cycle.
- Latency is 1 cycle: a word accepted at edge n appears on `out_data` with `out_valid` after edge n.
- Sustained throughput is 1 word/cycle while `out_ready`=1, including back-to-back transfers in the same burst and across owners.
- **Simultaneous consume and accept:** when `out_ready`=1 and a transfer happen in the same cycle, the slot is refilled and `out_valid` stays 1.
- **Reset mid-burst:** asserting `rst` mid-burst drops LOCKED, clears `out_valid`, and resets `ptr` to 0 at the next edge. The word in the output slot is discarded.
- `req_ready` is 0 for all requesters in any cycle where `rst`=1.

## Structure
- Shared package `reg_share_pkg`:
  - state enum `arb_state_e` {IDLE, LOCKED}.
  - default constants `REG_SHARE_DATA_W`=16 and `REG_SHARE_MAX_REQ`=16.
- Sub-module `rr_pick`: purely combinational rotate-priority selector, inputs (req vector, ptr), outputs (one-hot grant, index, any).
- The top level holds the FSM, burst counter and output register.

## Test plan
All scenarios use NUM_REQ=4 and MAX_BURST=2 unless noted.
- **Reset:** `rst` high 2 cycles with all req_valid=1 -> `req_ready`=0, `out_valid`=0, `out_data`=0, `out_src`=0. First grant after release goes to requester 0.
- **Full rotation:** all four valid with data 0x000i and `out_ready`=1 -> `out_src` sequence 0,0,1,1,2,2,3,3,0 on consecutive cycles, no bubbles, each word 1 cycle after its accept.
- **Owner drops:** requester 2 alone valid for 1 transfer then drops, requester 3 valid -> one idle cycle (`req_ready`=0), then requester 3 granted, `ptr` now 3.
- **Backpressure:** requester 1 streams 0x0011, 0x0012 with `out_ready`=0 for 3 cycles after the first accept -> `out_data` holds 0x0011 and `req_ready[1]`=0 during the stall. 0x0012 is accepted on the cycle `out_ready` returns, and `out_valid` stays 1.
- **MAX_BURST=1, requesters 0 and 3 valid:** grants alternate 0,3,0,3. Wrap from ptr=3 to 0 is verified.
- **Reset mid-burst:** `rst` asserted after the first transfer of a burst from requester 2 -> next cycle IDLE, `out_valid`=0. After release, requester 0 wins over 2 when both are valid.
